// File: rtl/temporal_encoder.sv
// temporal_encoder: replays binary value vectors as race-logic temporal codes,
// one gamma cycle of GAMMA_CYCLE_WIDTH clocks per vector, double-buffered.
module temporal_encoder #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int NUM_INPUTS        = GAMMA_CYCLE_WIDTH,
  parameter int VAL_WIDTH         = $clog2(GAMMA_CYCLE_WIDTH) + 1,
  parameter bit PULSE_MODE        = 1'b0
) (
  input  logic                            aclk,
  input  logic                            grst,
  input  logic [NUM_INPUTS*VAL_WIDTH-1:0] in_values,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [NUM_INPUTS-1:0]           y,
  output logic                            gamma_start,
  output logic                            busy
);
  localparam int TW     = $clog2(GAMMA_CYCLE_WIDTH);
  // Extra headroom so v + PULSE_WIDTH can never wrap in the compare.
  localparam int CW     = VAL_WIDTH + 1 + $clog2(PULSE_WIDTH + 1);
  localparam int VW_ALL = NUM_INPUTS * VAL_WIDTH;
  localparam logic [TW-1:0] T_LAST = TW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [CW-1:0] G_C    = CW'(GAMMA_CYCLE_WIDTH);
  localparam logic [CW-1:0] PW_C   = CW'(PULSE_WIDTH);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                  state_r, state_nxt;
  logic [TW-1:0]           t_r, t_nxt;
  logic [VW_ALL-1:0]       active_r, active_nxt;
  logic [VW_ALL-1:0]       pending_r, pending_nxt;
  logic                    pv_r, pv_nxt;
  logic [NUM_INPUTS-1:0]   y_r, y_nxt;
  logic                    gs_r, gs_nxt;
  logic                    xfer_s;

  // Line i is high at cycle t per the rising or pulse law; t < G clips pulses.
  function automatic logic [NUM_INPUTS-1:0] encode(input logic [VW_ALL-1:0] vec,
                                                   input logic [TW-1:0] t);
    logic [CW-1:0]         v;
    logic [CW-1:0]         tc;
    logic [NUM_INPUTS-1:0] res;
    res = {NUM_INPUTS{1'b0}};
    tc  = CW'(t);
    for (int i = 0; i < NUM_INPUTS; i++) begin
      v = CW'(vec[i*VAL_WIDTH +: VAL_WIDTH]);
      if (PULSE_MODE) begin
        res[i] = (v < G_C) && (tc >= v) && (tc < v + PW_C);
      end else begin
        res[i] = (v < G_C) && (tc >= v);
      end
    end
    return res;
  endfunction

  assign xfer_s      = in_valid && !pv_r;
  assign in_ready    = !pv_r;
  assign busy        = (state_r == RUN);
  assign y           = y_r;
  assign gamma_start = gs_r;

  // Next-state, buffer handover and next-cycle output computation.
  always_comb begin
    state_nxt   = state_r;
    t_nxt       = t_r;
    active_nxt  = active_r;
    pending_nxt = pending_r;
    pv_nxt      = pv_r;
    case (state_r)
      IDLE: begin
        t_nxt = {TW{1'b0}};
        if (xfer_s) begin
          state_nxt  = RUN;
          active_nxt = in_values;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (t_r == T_LAST) begin
          t_nxt = {TW{1'b0}};
          if (pv_r) begin
            active_nxt = pending_r;
            pv_nxt     = 1'b0;
          end else if (xfer_s) begin
            active_nxt = in_values;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          t_nxt = t_r + TW'(1);
          if (xfer_s) begin
            pending_nxt = in_values;
            pv_nxt      = 1'b1;
          end else begin
            pv_nxt = pv_r;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        t_nxt     = {TW{1'b0}};
      end
    endcase
    if (state_nxt == RUN) begin
      y_nxt  = encode(active_nxt, t_nxt);
      gs_nxt = (t_nxt == {TW{1'b0}});
    end else begin
      y_nxt  = {NUM_INPUTS{1'b0}};
      gs_nxt = 1'b0;
    end
  end

  // State, buffers and registered outputs with synchronous reset.
  always_ff @(posedge aclk) begin
    if (grst) begin
      state_r   <= IDLE;
      t_r       <= {TW{1'b0}};
      active_r  <= {VW_ALL{1'b0}};
      pending_r <= {VW_ALL{1'b0}};
      pv_r      <= 1'b0;
      y_r       <= {NUM_INPUTS{1'b0}};
      gs_r      <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      t_r       <= t_nxt;
      active_r  <= active_nxt;
      pending_r <= pending_nxt;
      pv_r      <= pv_nxt;
      y_r       <= y_nxt;
      gs_r      <= gs_nxt;
    end
  end

endmodule
